// File: rtl/des_key_scheduler_pkg.sv
// Shared DES key-schedule definitions: widths, PC-1/PC-2 tables,
// per-round rotation amounts and the scheduler FSM state type.
package des_key_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Entries are DES bit numbers (1 = MSB of the source vector)
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:0] shift_amt(input logic [3:0] round);
    case (round)
      4'd0, 4'd1, 4'd8, 4'd15: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [2*HALF_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < 2*HALF_W; i++)
      res[6'(2*HALF_W-1-i)] = key[6'(KEY_W-PC1_TAB[i])];
    return res;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [2*HALF_W-1:0] cd);
    logic [SUBKEY_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++)
      res[6'(SUBKEY_W-1-i)] = cd[6'(2*HALF_W-PC2_TAB[i])];
    return res;
  endfunction

endpackage

// File: rtl/des_key_scheduler_if.sv
// Control and subkey handshake bundle between the key scheduler (slave)
// and whoever loads keys and consumes subkeys (master).
interface des_key_scheduler_if;
  import des_key_pkg::*;

  logic                start;
  logic                abort;
  logic [KEY_W-1:0]    key;
  logic                decrypt;
  logic                busy;
  logic [SUBKEY_W-1:0] subkey;
  logic [3:0]          subkey_round;
  logic                subkey_valid;
  logic                subkey_ready;
  logic                done;

  modport slave (
    input  start, abort, key, decrypt, subkey_ready,
    output busy, subkey, subkey_round, subkey_valid, done
  );

  modport master (
    output start, abort, key, decrypt, subkey_ready,
    input  busy, subkey, subkey_round, subkey_valid, done
  );
endinterface

// File: rtl/des_key_scheduler_rotator.sv
// Combinational C/D step: rotate left for encrypt, right for decrypt,
// by the DES shift amount that belongs to the transition being taken.
module des_key_rotator
  import des_key_pkg::*;
(
  input  logic [HALF_W-1:0] Ci,
  input  logic [HALF_W-1:0] Di,
  input  logic [3:0]        round,
  input  logic              decrypt,
  output logic [HALF_W-1:0] Ci_shift,
  output logic [HALF_W-1:0] Di_shift
);
  logic [3:0] w_round_inc;
  logic [1:0] w_amt;

  // Encrypt builds C(r+2) so uses the next round's shift; decrypt undoes
  // the shift that produced the round just emitted.
  assign w_round_inc = round + 4'd1;
  assign w_amt       = decrypt ? shift_amt(round) : shift_amt(w_round_inc);

  always_comb begin
    Ci_shift = Ci;
    Di_shift = Di;
    if (!decrypt) begin
      if (w_amt == 2'd1) begin
        Ci_shift = {Ci[HALF_W-2:0], Ci[HALF_W-1]};
        Di_shift = {Di[HALF_W-2:0], Di[HALF_W-1]};
      end else begin
        Ci_shift = {Ci[HALF_W-3:0], Ci[HALF_W-1:HALF_W-2]};
        Di_shift = {Di[HALF_W-3:0], Di[HALF_W-1:HALF_W-2]};
      end
    end else begin
      if (w_amt == 2'd1) begin
        Ci_shift = {Ci[0], Ci[HALF_W-1:1]};
        Di_shift = {Di[0], Di[HALF_W-1:1]};
      end else begin
        Ci_shift = {Ci[1:0], Ci[HALF_W-1:2]};
        Di_shift = {Di[1:0], Di[HALF_W-1:2]};
      end
    end
  end
endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: PC-1 on start, then one PC-2 subkey per
// accepted handshake, K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_scheduler
  import des_key_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  des_key_scheduler_if.slave bus
);
  state_t              r_state, w_state_nxt;
  logic [HALF_W-1:0]   r_c, r_d, w_c_nxt, w_d_nxt, w_c_rot, w_d_rot;
  logic [3:0]          r_round, w_round_nxt;
  logic                r_dec, w_dec_nxt;
  logic [2*HALF_W-1:0] w_pc1;
  logic                w_last;

  assign w_pc1  = pc1(bus.key);
  assign w_last = r_dec ? (r_round == 4'd0) : (r_round == 4'd15);

  des_key_rotator u_rotator (
    .Ci       (r_c),
    .Di       (r_d),
    .round    (r_round),
    .decrypt  (r_dec),
    .Ci_shift (w_c_rot),
    .Di_shift (w_d_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_round <= w_round_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_round_nxt = r_round;
    w_dec_nxt   = r_dec;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_c_nxt     = '0;
      w_d_nxt     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_state_nxt = ST_EMIT;
            w_dec_nxt   = bus.decrypt;
            // Decrypt starts from C16/D16, which equal the unrotated C0/D0
            if (bus.decrypt) begin
              w_c_nxt     = w_pc1[2*HALF_W-1:HALF_W];
              w_d_nxt     = w_pc1[HALF_W-1:0];
              w_round_nxt = 4'd15;
            end else begin
              w_c_nxt     = {w_pc1[2*HALF_W-2:HALF_W], w_pc1[2*HALF_W-1]};
              w_d_nxt     = {w_pc1[HALF_W-2:0], w_pc1[HALF_W-1]};
              w_round_nxt = 4'd0;
            end
          end
        end
        ST_EMIT: begin
          if (bus.subkey_ready) begin
            if (w_last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_c_nxt     = w_c_rot;
              w_d_nxt     = w_d_rot;
              w_round_nxt = r_dec ? (r_round - 4'd1) : (r_round + 4'd1);
            end
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.subkey_valid = (r_state == ST_EMIT);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.subkey_round = r_round;
  assign bus.subkey       = pc2({r_c, r_d});
endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic 133457799BBCDFF1
// key schedule, all-zero/all-one keys, stalls, abort and mid-run reset.
module tb_des_key_scheduler;
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0; // KEY_A with parity bits flipped

  logic [47:0] K_TAB [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  des_key_scheduler_if bus();

  des_key_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] exp_sub(input int unsigned kind, input int unsigned idx);
    case (kind)
      1:       return '0;
      2:       return '1;
      default: return K_TAB[idx];
    endcase
  endfunction

  // Entered and left at a negedge with the scheduler idle.
  task automatic run_sched(input string name, input logic [63:0] k, input logic dec,
                           input int unsigned kind, input bit rnd, input int unsigned poke_at);
    int unsigned got, iters, idx;
    bit poked;
    got = 0; iters = 0; poked = 0;
    bus.key = k; bus.decrypt = dec; bus.start = 1'b1; bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.key = ~k; bus.decrypt = ~dec;
    check({name, " busy_start"}, 64'(bus.busy), 64'd1);
    while (got < 16 && iters < 200) begin
      bus.start = 1'b0;
      if (got == poke_at && !poked) begin
        bus.start = 1'b1; bus.key = 64'h0123456789ABCDEF; poked = 1;
      end
      bus.subkey_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      idx = dec ? 15 - got : got;
      check($sformatf("%s valid[%0d]", name, got), 64'(bus.subkey_valid), 64'd1);
      check($sformatf("%s round[%0d]", name, got), 64'(bus.subkey_round), 64'(idx));
      check($sformatf("%s subkey[%0d]", name, got), 64'(bus.subkey), 64'(exp_sub(kind, idx)));
      if (bus.subkey_ready) got++;
      @(negedge clk);
      iters++;
    end
    bus.start = 1'b0;
    check({name, " count"}, 64'(got), 64'd16);
    if (!rnd) check({name, " cycles"}, 64'(iters), 64'd16);
    check({name, " done"}, 64'(bus.done), 64'd1);
    check({name, " valid_done"}, 64'(bus.subkey_valid), 64'd0);
    @(negedge clk);
    check({name, " done_low"}, 64'(bus.done), 64'd0);
    check({name, " busy_low"}, 64'(bus.busy), 64'd0);
    bus.subkey_ready = 1'b0;
  endtask

  initial begin
    int unsigned n;
    bus.start = 1'b0; bus.abort = 1'b0; bus.key = '0;
    bus.decrypt = 1'b0; bus.subkey_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst valid", 64'(bus.subkey_valid), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst subkey", 64'(bus.subkey), 64'd0);
    check("rst round", 64'(bus.subkey_round), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sched("enc", KEY_A, 1'b0, 0, 1'b0, 99);
    run_sched("dec", KEY_A, 1'b1, 0, 1'b0, 99);
    run_sched("zero", 64'h0, 1'b0, 1, 1'b0, 99);
    run_sched("ones", 64'hFFFFFFFFFFFFFFFF, 1'b1, 2, 1'b0, 99);
    run_sched("parity", KEY_P, 1'b0, 0, 1'b0, 99);
    run_sched("stall_enc", KEY_A, 1'b0, 0, 1'b1, 99);
    run_sched("stall_dec", KEY_A, 1'b1, 0, 1'b1, 99);
    run_sched("poke", KEY_A, 1'b0, 0, 1'b0, 4);

    // abort at round 5
    bus.key = KEY_A; bus.decrypt = 1'b0; bus.start = 1'b1; bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.subkey_round != 4'd5 && n < 40) begin @(negedge clk); n++; end
    check("abort reach_r5", 64'(bus.subkey_round), 64'd5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort valid", 64'(bus.subkey_valid), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort subkey", 64'(bus.subkey), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort no_done", 64'(bus.done), 64'd0);
      @(negedge clk);
    end

    // start and abort together while idle
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start busy", 64'(bus.busy), 64'd0);
    check("abort_start valid", 64'(bus.subkey_valid), 64'd0);
    run_sched("post_abort", KEY_A, 1'b0, 0, 1'b0, 99);

    // reset at round 9
    bus.key = KEY_A; bus.decrypt = 1'b0; bus.start = 1'b1; bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.subkey_round != 4'd9 && n < 40) begin @(negedge clk); n++; end
    check("rst9 reach_r9", 64'(bus.subkey_round), 64'd9);
    rst_n = 1'b0;
    #1;
    check("rst9 busy", 64'(bus.busy), 64'd0);
    check("rst9 valid", 64'(bus.subkey_valid), 64'd0);
    check("rst9 done", 64'(bus.done), 64'd0);
    check("rst9 subkey", 64'(bus.subkey), 64'd0);
    check("rst9 round", 64'(bus.subkey_round), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    check("rst9 idle_done", 64'(bus.done), 64'd0);
    run_sched("post_rst", KEY_A, 1'b0, 0, 1'b0, 99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
